// File: rtl/memory_port_arbiter.sv
// Shares one external memory port between instruction fetch and the data path.
// Data side wins by default; fetch is forced after STARVE_LIMIT data grants.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | no access in flight; arbitration happens here only
//  FETCH  | instruction read strobed, waiting for m_wait==0
//  DREAD  | data load strobed
//  DWRITE | data store strobed
//  XREAD  | exchange, read half; rolls straight into XWRITE
//  XWRITE | exchange, write half to the same address
module memory_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_wait,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        XREAD  = 3'd4,
        XWRITE = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             data_elig;

    // A data request with neither direction flag is not a real request.
    assign data_elig = d_req & (d_read | d_write);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            f_done     <= 1'b0;
            f_rdata    <= '0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            m_addr     <= '0;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            m_wdata    <= '0;
            busy       <= 1'b0;
        end else begin
            f_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (f_req && starve_cnt == LIMIT) begin
                        state      <= FETCH;
                        m_addr     <= f_addr;
                        m_read     <= 1'b1;
                        starve_cnt <= '0;
                        busy       <= 1'b1;
                    end else if (data_elig) begin
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_read  <= d_read;
                        m_write <= d_write & ~d_read;
                        busy    <= 1'b1;
                        if (d_read && d_write) state <= XREAD;
                        else if (d_read)       state <= DREAD;
                        else                   state <= DWRITE;
                        if (f_req && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (f_req) begin
                        state      <= FETCH;
                        m_addr     <= f_addr;
                        m_read     <= 1'b1;
                        starve_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!m_wait) begin
                        f_rdata <= m_rdata;
                        f_done  <= 1'b1;
                        m_read  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DREAD: begin
                    if (!m_wait) begin
                        d_rdata <= m_rdata;
                        d_done  <= 1'b1;
                        m_read  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                XREAD: begin
                    // Switch straight to the write half so nothing can slip in between.
                    if (!m_wait) begin
                        d_rdata <= m_rdata;
                        m_read  <= 1'b0;
                        m_write <= 1'b1;
                        state   <= XWRITE;
                    end
                end
                DWRITE, XWRITE: begin
                    if (!m_wait) begin
                        d_done  <= 1'b1;
                        m_write <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_read  <= 1'b0;
                    m_write <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
